// File: rtl/number_console.sv
// number_console: FIFO-buffered printer that turns signed 32-bit values and newlines into
// SCROLL / POS CLEAR / NUMBER commands for the text display. Build macro: NUMBER_CONSOLE_CLEAR_EN.
module number_console #(
   parameter int         DEPTH = 8,
   parameter int         COLS  = 4,
   parameter logic [7:0] ROW   = 8'd44
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic        in_nl,
   input  logic [31:0] in_value,
   output logic        in_ready,
   input  logic        disp_ready,
   output logic [3:0]  cmd,
   output logic [47:0] data,
   output logic        busy
);
   // state | meaning
   // IDLE  | no entry held; pops the FIFO head and builds its op list
   // WAIT  | current op pending until the display reports ready
   // ISSUE | cmd is non-zero for this single cycle
   // HOLD  | display ready is combinational on cmd, so skip one cycle
   typedef enum logic [1:0] {IDLE, WAIT, ISSUE, HOLD} state_t;

   localparam int         AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int         CW         = AW + 1;
   localparam logic [7:0] COLS_L     = 8'(COLS);
   localparam logic [3:0] CMD_NOP    = 4'h0;
   localparam logic [3:0] CMD_SCROLL = 4'h1;
   localparam logic [3:0] CMD_NUMBER = 4'h3;
`ifdef NUMBER_CONSOLE_CLEAR_EN
   localparam logic [3:0] CMD_CLEAR  = 4'h2;
`endif
   localparam int         OP_SCROLL  = 0;
   localparam int         OP_CLEAR   = 1;
   localparam int         OP_NUMBER  = 2;

   logic [32:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          push, pop, full, empty;
   logic [32:0]   head;

   state_t        state, state_d;
   logic [2:0]    ops, ops_d;
   logic [7:0]    col, col_d;
   logic [31:0]   val, val_d;
   logic [3:0]    cmd_d;
   logic [47:0]   data_d;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign in_ready = !rst && !full;
   assign push     = in_valid && in_ready;
   assign head     = mem[rd_ptr];
   assign busy     = !empty || (state != IDLE);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {in_nl, in_value};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ops   <= '0;
         col   <= '0;
         val   <= '0;
         cmd   <= CMD_NOP;
         data  <= '0;
      end else begin
         state <= state_d;
         ops   <= ops_d;
         col   <= col_d;
         val   <= val_d;
         cmd   <= cmd_d;
         data  <= data_d;
      end
   end

   always_comb begin
      state_d = state;
      ops_d   = ops;
      col_d   = col;
      val_d   = val;
      cmd_d   = cmd;
      data_d  = data;
      pop     = 1'b0;
      unique case (state)
         IDLE: begin
            if (!empty) begin
               pop   = 1'b1;
               val_d = head[31:0];
               ops_d = '0;
               if (head[32]) begin
                  ops_d[OP_SCROLL] = 1'b1;
               end else begin
                  // col==COLS is a deferred wrap, paid for only when the next value arrives
                  ops_d[OP_SCROLL] = (col == COLS_L);
`ifdef NUMBER_CONSOLE_CLEAR_EN
                  ops_d[OP_CLEAR]  = 1'b1;
`else
                  ops_d[OP_CLEAR]  = 1'b0;
`endif
                  ops_d[OP_NUMBER] = 1'b1;
               end
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (disp_ready) begin
               state_d = ISSUE;
               if (ops[OP_SCROLL]) begin
                  cmd_d            = CMD_SCROLL;
                  data_d           = '0;
                  col_d            = '0;
                  ops_d[OP_SCROLL] = 1'b0;
               end
`ifdef NUMBER_CONSOLE_CLEAR_EN
               else if (ops[OP_CLEAR]) begin
                  cmd_d           = CMD_CLEAR;
                  data_d          = {8'd0, col, ROW, 32'd0};
                  ops_d[OP_CLEAR] = 1'b0;
               end
`endif
               else begin
                  cmd_d            = CMD_NUMBER;
                  data_d           = {8'd0, col, ROW, val};
                  col_d            = col + 8'd1;
                  ops_d[OP_NUMBER] = 1'b0;
               end
            end
         end
         ISSUE: begin
            cmd_d   = CMD_NOP;
            data_d  = '0;
            state_d = HOLD;
         end
         HOLD: begin
            state_d = (ops != '0) ? WAIT : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_number_console.sv
// Self-checking bench for number_console: directed scenarios plus randomized traffic,
// all checked against a command-list model derived from column arithmetic.
module tb_number_console;
   localparam int         DEPTH = 8;
   localparam int         COLS  = 4;
   localparam logic [7:0] ROW   = 8'd44;
`ifdef NUMBER_CONSOLE_CLEAR_EN
   localparam bit CLEAR_EN = 1'b1;
`else
   localparam bit CLEAR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_nl = 1'b0;
   logic [31:0] in_value = '0;
   logic        disp_ready = 1'b0;
   logic        in_ready, busy;
   logic [3:0]  cmd;
   logic [47:0] data;

   always #5 clk = ~clk;

   number_console #(.DEPTH(DEPTH), .COLS(COLS), .ROW(ROW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_nl(in_nl), .in_value(in_value),
      .in_ready(in_ready), .disp_ready(disp_ready), .cmd(cmd), .data(data), .busy(busy)
   );

   typedef struct { logic [3:0] c; logic [47:0] d; } exp_t;
   exp_t exp_q[$];
   int   mcol = 0;
   int   n_checks = 0, n_fail = 0;
   int   cyc = 0, n_issued = 0, last_issue_cyc = 0, last_push_cyc = 0;
   logic dr_prev = 1'b0;
   bit   rnd_done = 1'b0;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      dr_prev <= disp_ready;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Expected command list for one entry, from the column rules alone.
   task automatic model_push(input logic nl, input logic [31:0] v);
      exp_t e;
      if (nl) begin
         e.c = 4'h1; e.d = '0; exp_q.push_back(e);
         mcol = 0;
      end else begin
         if (mcol == COLS) begin
            e.c = 4'h1; e.d = '0; exp_q.push_back(e);
            mcol = 0;
         end
         if (CLEAR_EN) begin
            e.c = 4'h2; e.d = {8'd0, 8'(mcol), ROW, 32'd0}; exp_q.push_back(e);
         end
         e.c = 4'h3; e.d = {8'd0, 8'(mcol), ROW, v}; exp_q.push_back(e);
         mcol++;
      end
   endtask

   always @(negedge clk) begin
      if (cmd != 4'h0) begin
         if (n_issued > 0) chk("spacing>=3", (cyc - last_issue_cyc) >= 3, 1'b1);
         chk("issue_on_ready", dr_prev, 1'b1);
         if (exp_q.size() == 0) begin
            chk("unexpected_cmd", cmd, 4'h0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("cmd", cmd, e.c);
            chk("data", data, e.d);
         end
         n_issued++;
         last_issue_cyc = cyc;
      end
   end

   task automatic send(input logic nl, input logic [31:0] v);
      int n = 0;
      @(negedge clk);
      in_valid = 1'b1; in_nl = nl; in_value = v;
      while (!in_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (in_ready) begin
         model_push(nl, v);
         @(posedge clk);
         #1;
         last_push_cyc = cyc;
      end else begin
         chk("send_timeout", in_ready, 1'b1);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_issue(input int n0);
      int n = 0;
      while (n_issued == n0 && n < 500) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("issue_timeout", n_issued != n0, 1'b1);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("drain_queue", exp_q.size(), 0);
      chk("drain_busy", busy, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; exp_q.delete(); mcol = 0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_cmd", cmd, 4'h0);
      rst = 1'b0;
   endtask

   initial begin
      int n0, n1, rel;
      logic nl;
      repeat (3) @(negedge clk);
      chk("reset_cmd", cmd, 4'h0);
      chk("reset_data", data, 48'd0);
      chk("reset_in_ready", in_ready, 1'b0);
      chk("reset_busy", busy, 1'b0);
      rst = 1'b0;
      #1;
      chk("in_ready_after_reset", in_ready, 1'b1);
      disp_ready = 1'b1;

      // single value, first command two edges after the push
      n0 = n_issued;
      send(1'b0, 32'hFFFF_FFF9);
      wait_issue(n0);
      chk("first_cmd_latency", last_issue_cyc, last_push_cyc + 2);
      drain();

      // row wrap
      do_reset();
      for (int v = 1; v <= 5; v++) send(1'b0, 32'(v));
      drain();

      // newlines from col=2, then a value lands at x=0
      do_reset();
      send(1'b0, 32'd1);
      send(1'b0, 32'd2);
      send(1'b1, 32'd0);
      send(1'b1, 32'd0);
      drain();
      send(1'b0, 32'd7);
      drain();

      // backpressure: one entry sits in the holding register, DEPTH more fill the FIFO
      disp_ready = 1'b0;
      n0 = n_issued;
      for (int k = 1; k <= DEPTH + 1; k++) begin
         send(1'b0, 32'(100 + k));
         chk("bp_in_ready", in_ready, k <= DEPTH);
      end
      fork
         send(1'b0, 32'd200);
         begin
            repeat (6) @(negedge clk);
            chk("bp_blocked", in_ready, 1'b0);
            chk("bp_no_cmd", n_issued, n0);
            chk("bp_cmd_zero", cmd, 4'h0);
            #1 disp_ready = 1'b1;
         end
      join
      drain();

      // display-busy stall right after the first command of a value
      n0 = n_issued;
      send(1'b0, 32'd55);
      send(1'b0, 32'd66);
      wait_issue(n0);
      disp_ready = 1'b0;
      n1 = n_issued;
      repeat (40) @(negedge clk);
      chk("stall_quiet", n_issued, n1);
      rel = cyc + 1;
      disp_ready = 1'b1;
      wait_issue(n1);
      chk("stall_release_cycle", last_issue_cyc, rel);
      drain();

      // reset while a command is on the bus
      n0 = n_issued;
      send(1'b0, 32'd77);
      wait_issue(n0);
      rst = 1'b1; exp_q.delete(); mcol = 0;
      @(negedge clk);
      #1;
      chk("midrst_cmd", cmd, 4'h0);
      chk("midrst_in_ready", in_ready, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_busy", busy, 1'b0);
      n1 = n_issued;
      repeat (20) @(negedge clk);
      chk("midrst_no_number", n_issued, n1);
      send(1'b0, 32'd88);
      drain();

      // randomized traffic with a flaky display
      fork
         begin
            for (int i = 0; i < 120; i++) begin
               repeat ($urandom_range(0, 3)) @(negedge clk);
               nl = ($urandom_range(0, 7) == 0);
               send(nl, $urandom);
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(negedge clk);
               #2 disp_ready = ($urandom_range(0, 3) != 0);
            end
            disp_ready = 1'b1;
         end
      join
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1);
   end
endmodule
